// File: rtl/t_toggle_pkg.sv
// Shared types and defaults for the toggle monitor.
// Optional feature macro used by this slice: T_TOGGLE_MONITOR_SYNC_EN.
package t_toggle_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SAT  = 2'b10
  } state_t;

endpackage

// File: rtl/t_edge_det.sv
// Level-change detector for the toggle input.
// T_TOGGLE_MONITOR_SYNC_EN adds a 2-flop synchronizer in front of detection.
module t_edge_det
  import t_toggle_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tog,
  input  logic i_clr,
  output logic o_edge_pulse,
  output logic o_edge_c
);

  logic w_samp;
  logic r_tog_q;
  logic r_edge_pulse;

`ifdef T_TOGGLE_MONITOR_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchronizer for an asynchronous upstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_tog;
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp = r_sync2;
`else
  assign w_samp = i_tog;
`endif

  // Previous sampled level; keeps tracking through clr so no spurious edge follows it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tog_q <= 1'b0;
    else     r_tog_q <= w_samp;
  end

  assign o_edge_c = w_samp ^ r_tog_q;

  // Registered edge pulse; clr suppresses an edge arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_edge_pulse <= 1'b0;
    else     r_edge_pulse <= o_edge_c & ~i_clr;
  end

  assign o_edge_pulse = r_edge_pulse;

endmodule

// File: rtl/t_toggle_monitor.sv
// Toggle monitor: edge pulses, edge count with sticky wrap, and inter-edge period.
// T_TOGGLE_MONITOR_SYNC_EN selects synchronized sampling of tog_in.
module t_toggle_monitor
  import t_toggle_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] count,
  output logic             cnt_wrap,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             per_ovf
);

  localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GAP_PRE = GAP_MAX - CNT_W'(1);

  logic             w_edge;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_cnt_wrap;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_per_ovf;

  t_edge_det u_edge_det (
    .clk         (clk),
    .rst         (rst),
    .i_tog       (tog_in),
    .i_clr       (clr),
    .o_edge_pulse(edge_pulse),
    .o_edge_c    (w_edge)
  );

  // Edge counter, gap counter and period FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_cnt_wrap     <= 1'b0;
      r_gap          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_per_ovf      <= 1'b0;
    end else if (clr) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_cnt_wrap     <= 1'b0;
      r_gap          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_per_ovf      <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;

      if (w_edge) begin
        r_count <= r_count + CNT_W'(1);
        if (r_count == GAP_MAX) r_cnt_wrap <= 1'b1;
        r_gap <= '0;
      end else if (r_gap != GAP_MAX) begin
        r_gap <= r_gap + CNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_edge) r_state <= RUN;
        end
        RUN: begin
          if (w_edge) begin
            r_period       <= r_gap + CNT_W'(1);
            r_per_ovf      <= 1'b0;
            r_period_valid <= 1'b1;
          end else if (r_gap == GAP_PRE) begin
            r_state <= SAT;
          end
        end
        SAT: begin
          if (w_edge) begin
            r_period       <= GAP_MAX;
            r_per_ovf      <= 1'b1;
            r_period_valid <= 1'b1;
            r_state        <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count        = r_count;
  assign cnt_wrap     = r_cnt_wrap;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign per_ovf      = r_per_ovf;

endmodule

// File: tb/tb_t_toggle_monitor.sv
// Directed bench for t_toggle_monitor (CNT_W=4, direct sampling build).
module tb_t_toggle_monitor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         tog_in;
  logic         clr;
  logic         edge_pulse;
  logic [W-1:0] count;
  logic         cnt_wrap;
  logic [W-1:0] period;
  logic         period_valid;
  logic         per_ovf;

  int n_cmp = 0;
  int n_err = 0;

  t_toggle_monitor #(.CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tog_in      (tog_in),
    .clr         (clr),
    .edge_pulse  (edge_pulse),
    .count       (count),
    .cnt_wrap    (cnt_wrap),
    .period      (period),
    .period_valid(period_valid),
    .per_ovf     (per_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ep, input int e_cnt, input logic e_wrap,
                         input int e_per, input logic e_pv, input logic e_ovf);
    chk({tag, ".edge_pulse"},   32'(edge_pulse),   32'(e_ep));
    chk({tag, ".count"},        32'(count),        32'(e_cnt));
    chk({tag, ".cnt_wrap"},     32'(cnt_wrap),     32'(e_wrap));
    chk({tag, ".period"},       32'(period),       32'(e_per));
    chk({tag, ".period_valid"}, 32'(period_valid), 32'(e_pv));
    chk({tag, ".per_ovf"},      32'(per_ovf),      32'(e_ovf));
  endtask

  initial begin
    rst    = 1'b1;
    clr    = 1'b0;
    tog_in = 1'b0;

    // Reset held while tog_in toggles: everything stays zero
    for (int i = 0; i < 4; i++) begin
      tog_in = ~tog_in;
      tick();
      chk_all($sformatf("rst_hold%0d", i), 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    end
    tog_in = 1'b0;
    rst    = 1'b0;
    tick();
    chk_all("rst_release", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Five edges one cycle apart from IDLE
    for (int k = 1; k <= 5; k++) begin
      tog_in = ~tog_in;
      tick();
      chk_all($sformatf("cont%0d", k), 1'b1, k, 1'b0, (k > 1) ? 1 : 0, k > 1, 1'b0);
    end
    tick();
    chk_all("cont_hold", 1'b0, 5, 1'b0, 1, 1'b0, 1'b0);

    // One idle cycle already elapsed, so the next edge reports period 2
    tog_in = ~tog_in;
    tick();
    chk_all("gap2", 1'b1, 6, 1'b0, 2, 1'b1, 1'b0);

    // Toggle every 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("p3_idle_a%0d", i), 1'b0, 6 + i, 1'b0, (i == 0) ? 2 : 3, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("p3_idle_b%0d", i), 1'b0, 6 + i, 1'b0, (i == 0) ? 2 : 3, 1'b0, 1'b0);
      tog_in = ~tog_in;
      tick();
      chk_all($sformatf("p3_edge%0d", i), 1'b1, 7 + i, 1'b0, 3, 1'b1, 1'b0);
    end

    // Plain synchronous clear
    clr = 1'b1;
    tick();
    chk_all("clr", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    clr = 1'b0;

    // 17 back-to-back edges: count wraps at the 16th
    for (int k = 1; k <= 17; k++) begin
      tog_in = ~tog_in;
      tick();
      chk_all($sformatf("wrap%0d", k), 1'b1, k % 16, k >= 16, (k > 1) ? 1 : 0, k > 1, 1'b0);
    end

    // Long gap drives the FSM into saturation
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all($sformatf("satgap%0d", i), 1'b0, 1, 1'b1, 1, 1'b0, 1'b0);
    end
    tog_in = ~tog_in;
    tick();
    chk_all("sat_edge", 1'b1, 2, 1'b1, 15, 1'b1, 1'b1);
    tick();
    chk_all("sat_hold", 1'b0, 2, 1'b1, 15, 1'b0, 1'b1);
    tog_in = ~tog_in;
    tick();
    chk_all("after_sat", 1'b1, 3, 1'b1, 2, 1'b1, 1'b0);

    // Edge exactly 15 cycles later stays in RUN: period 15 without overflow
    for (int i = 0; i < 14; i++) tick();
    chk_all("p15_pre", 1'b0, 3, 1'b1, 2, 1'b0, 1'b0);
    tog_in = ~tog_in;
    tick();
    chk_all("p15_edge", 1'b1, 4, 1'b1, 15, 1'b1, 1'b0);

    // clr coincident with an edge: clr wins, FSM back to IDLE
    tog_in = ~tog_in;
    clr    = 1'b1;
    tick();
    chk_all("clr_edge", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    chk_all("clr_after", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tog_in = ~tog_in;
    tick();
    chk_all("idle_edge", 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    tick();
    tog_in = ~tog_in;
    tick();
    chk_all("run_edge", 1'b1, 2, 1'b0, 2, 1'b1, 1'b0);

    // Async reset mid-gap
    tick();
    tick();
    chk_all("pre_rst", 1'b0, 2, 1'b0, 2, 1'b0, 1'b0);
    #2;
    rst    = 1'b1;
    tog_in = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("rst_low", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_all("first_edge_hi", 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_all("first_edge_done", 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/t_toggle_monitor.md
# t_toggle_monitor

Consumes the level output of a toggle flip-flop stage and turns each toggle into a one-cycle event. Counts the events and measures the clock-cycle interval between consecutive toggles. Sits directly downstream of the T flip-flop and gives firmware and test logic a cycle-accurate view of toggle rate and activity.

## Interface
Parameters:
- CNT_W, default 8: width of the event counter, the gap counter and the period output.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tog_in, input, 1: toggle level from the upstream T flip-flop output.
- clr, input, 1: synchronous clear of counters, flags and FSM.
- edge_pulse, output, 1: one-cycle pulse per detected level change of tog_in.
- count, output, CNT_W: number of detected edges, modulo 2^CNT_W.
- cnt_wrap, output, 1: sticky; set when count wraps from all-ones to 0.
- period, output, CNT_W: cycles between the last two edges, saturating.
- period_valid, output, 1: one-cycle pulse when period/per_ovf update.
- per_ovf, output, 1: set with a period update when the gap saturated; held until the next update.

## Operation
- Edge detect:
  - tog_q registers the sampled tog_in every cycle.
  - edge = sampled tog_in != tog_q.
  - edge_pulse is a register loaded with edge.
- Counter:
  - On each edge, count <= count+1, wrapping modulo 2^CNT_W.
  - On the wrap, cnt_wrap <= 1 (sticky).
- Gap counter:
  - On an edge, gap <= 0.
  - Otherwise gap increments, saturating at 2^CNT_W-1.
- FSM states: IDLE, RUN, SAT.
  - IDLE: no edge yet since reset/clr. Edge -> RUN, gap <= 0, no period update.
  - RUN, edge: period <= gap+1, per_ovf <= 0, period_valid pulses, stay in RUN.
  - RUN, no edge: when gap reaches 2^CNT_W-2 and increments to max -> SAT.
  - SAT, edge: period <= 2^CNT_W-1, per_ovf <= 1, period_valid pulses, -> RUN, gap <= 0.
  - SAT, no edge: hold.
- clr:
  - Forces count, cnt_wrap, period, per_ovf, gap to 0, period_valid and edge_pulse to 0, and the FSM to IDLE.
  - tog_q keeps tracking, so no spurious edge is generated after clr.
  - clr and edge in the same cycle: clr wins and the edge is discarded.
- Edges separated by one cycle (tog_in toggling every cycle) are all detected; period = 1.

## Timing
- Reset values: edge_pulse=0, count=0, cnt_wrap=0, period=0, period_valid=0, per_ovf=0, tog_q=0, gap=0, FSM=IDLE.
- Because tog_q resets to 0, a tog_in held at 1 through reset release produces one edge on the first clock.
- Latency without sync: tog_in changes before edge k -> at edge k, edge_pulse=1 and count/period/period_valid updated. Outputs are valid during cycle k.
- Latency with sync: 2 extra cycles, i.e. edge k+2.
- Async rst mid-measurement: all state returns to reset values immediately and no partial period is reported.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro: T_TOGGLE_MONITOR_SYNC_EN.
- Defined: tog_in passes through a 2-flop synchronizer (reset 0) before edge detection. Use this for an asynchronous upstream.
- Undefined: tog_in is sampled directly and latency is 1 cycle. Valid only when the upstream flip-flop shares clk.

## Structure
- Shared package t_toggle_pkg holds:
  - the FSM state typedef (IDLE/RUN/SAT, 2-bit encoding 00/01/10);
  - the default CNT_W constant.
- One sub-module: t_edge_det.
  - Contains the optional synchronizer, tog_q, and the registered edge_pulse.
  - Exports a combinational edge strobe to the parent.
- The counter, gap counter and FSM live in the parent.

## Test plan
- Reset: hold rst=1 with tog_in toggling -> all outputs 0. Release with tog_in=0 -> no edge_pulse.
- Continuous toggle, 5 edges one cycle apart from IDLE -> edge_pulse high 5 consecutive cycles, count=5, period_valid 4 times with period=1.
- Toggle every 3 cycles -> period=3, per_ovf=0 on each period_valid.
- CNT_W=4, 17 edges -> count=1, cnt_wrap=1 from the 16th edge onward.
- CNT_W=4, 20-cycle gap in RUN -> FSM enters SAT; next edge gives period=15, per_ovf=1. Following 2-cycle gap gives period=2, per_ovf=0.
- clr asserted on the same cycle as an edge -> count=0, edge_pulse=0, FSM=IDLE. Async rst mid-gap -> immediate reset values, no period_valid.
